// File: rtl/riscv_trace_pkg.sv
// Shared types for the commit-trace monitor: record kinds, filter modes,
// field widths and the commit classifier/filter rules.
package riscv_trace_pkg;

  localparam int KIND_W  = 3;
  localparam int MODE_W  = 2;
  localparam int INSTR_W = 32;
  localparam int RD_W    = 5;

  typedef enum logic [KIND_W-1:0] {
    KIND_NONE = 3'd0,
    KIND_REG  = 3'd1,
    KIND_MEM  = 3'd2,
    KIND_BR   = 3'd3,
    KIND_JUMP = 3'd4
  } kind_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_ALL    = 2'd0,
    MODE_EFFECT = 2'd1,
    MODE_CTRL   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // A write to x0 has no architectural effect, so it never makes a REG/JUMP record.
  function automatic kind_e classify(input logic reg_write, input logic [RD_W-1:0] rd,
                                     input logic mem_write, input logic branch_taken,
                                     input logic jump);
    logic rd_effect;
    rd_effect = reg_write && (rd != '0);
    if (rd_effect && jump) return KIND_JUMP;
    if (rd_effect)         return KIND_REG;
    if (mem_write)         return KIND_MEM;
    if (branch_taken)      return KIND_BR;
    return KIND_NONE;
  endfunction

  function automatic logic keep_kind(input mode_e mode, input kind_e kind);
    case (mode)
      MODE_ALL:    return 1'b1;
      MODE_EFFECT: return kind != KIND_NONE;
      MODE_CTRL:   return (kind == KIND_BR) || (kind == KIND_JUMP);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_commit_trace_buffer_if.sv
// Commit bus from the core and the valid/ready trace drain port to the host.
interface riscv_commit_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import riscv_trace_pkg::*;

  logic               commit_valid;
  logic [XLEN-1:0]    commit_pc;
  logic [INSTR_W-1:0] commit_instr;
  logic               commit_reg_write;
  logic [RD_W-1:0]    commit_rd;
  logic [XLEN-1:0]    commit_wdata;
  logic               commit_mem_write;
  logic [XLEN-1:0]    commit_mem_addr;
  logic [XLEN-1:0]    commit_mem_wdata;
  logic               commit_branch_taken;
  logic               commit_jump;
  logic [XLEN-1:0]    commit_next_pc;

  logic               trace_valid;
  logic               trace_ready;
  logic [KIND_W-1:0]  trace_kind;
  logic [CNT_W-1:0]   trace_seq;
  logic [XLEN-1:0]    trace_pc;
  logic [INSTR_W-1:0] trace_instr;
  logic [RD_W-1:0]    trace_rd;
  logic [XLEN-1:0]    trace_data0;
  logic [XLEN-1:0]    trace_data1;

  // Core plus host side
  modport master (
    output commit_valid, commit_pc, commit_instr, commit_reg_write, commit_rd,
           commit_wdata, commit_mem_write, commit_mem_addr, commit_mem_wdata,
           commit_branch_taken, commit_jump, commit_next_pc, trace_ready,
    input  trace_valid, trace_kind, trace_seq, trace_pc, trace_instr, trace_rd,
           trace_data0, trace_data1
  );

  // Trace buffer side
  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_reg_write, commit_rd,
           commit_wdata, commit_mem_write, commit_mem_addr, commit_mem_wdata,
           commit_branch_taken, commit_jump, commit_next_pc, trace_ready,
    output trace_valid, trace_kind, trace_seq, trace_pc, trace_instr, trace_rd,
           trace_data0, trace_data1
  );

endinterface

// File: rtl/riscv_trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head is read straight
// from the storage array and forced to zero while empty.
module riscv_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign level = r_wr_ptr - r_rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && (!full || w_do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_commit_trace_buffer.sv
// Commit-trace monitor: classifies retired instructions, stamps a sequence
// number, filters by mode and queues records for a valid/ready drain port.
module riscv_commit_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [MODE_W-1:0]           mode,
  input  logic                        flush,
  riscv_commit_trace_buffer_if.slave  bus,
  output logic [LVL_W-1:0]            level,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            overflow_count
);

  localparam int REC_W = KIND_W + CNT_W + XLEN + INSTR_W + RD_W + 2 * XLEN;

  logic [CNT_W-1:0] r_seq;
  logic [CNT_W-1:0] r_ovf;
  kind_e            w_kind;
  logic             w_push;
  logic             w_pop_eff;
  logic             w_drop;
  logic [RD_W-1:0]  w_rec_rd;
  logic [XLEN-1:0]  w_data0;
  logic [XLEN-1:0]  w_data1;
  logic [REC_W-1:0] w_wrec;
  logic [REC_W-1:0] w_rrec;

  assign w_kind = classify(bus.commit_reg_write, bus.commit_rd, bus.commit_mem_write,
                           bus.commit_branch_taken, bus.commit_jump);
  assign w_push = bus.commit_valid && en && keep_kind(mode_e'(mode), w_kind);

  always_comb begin
    w_rec_rd = '0;
    w_data0  = '0;
    w_data1  = '0;
    case (w_kind)
      KIND_REG: begin
        w_rec_rd = bus.commit_rd;
        w_data0  = bus.commit_wdata;
      end
      KIND_JUMP: begin
        w_rec_rd = bus.commit_rd;
        w_data0  = bus.commit_wdata;
        w_data1  = bus.commit_next_pc;
      end
      KIND_MEM: begin
        w_data0 = bus.commit_mem_addr;
        w_data1 = bus.commit_mem_wdata;
      end
      KIND_BR:  w_data0 = bus.commit_next_pc;
      default:  ;
    endcase
  end

  assign w_wrec = {w_kind, r_seq, bus.commit_pc, bus.commit_instr, w_rec_rd, w_data0, w_data1};

  riscv_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (bus.trace_ready),
    .flush (flush),
    .wdata (w_wrec),
    .rdata (w_rrec),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.trace_valid = !empty;
  assign {bus.trace_kind, bus.trace_seq, bus.trace_pc, bus.trace_instr, bus.trace_rd,
          bus.trace_data0, bus.trace_data1} = w_rrec;

  // Flushed pushes are discarded on purpose and are not counted as drops.
  assign w_pop_eff = bus.trace_ready && !empty;
  assign w_drop    = w_push && full && !w_pop_eff && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq <= '0;
      r_ovf <= '0;
    end else begin
      if (bus.commit_valid) r_seq <= r_seq + 1'b1;
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
    end
  end

  assign overflow_count = r_ovf;

endmodule
